// File: rtl/lcd12864_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lcd12864_bus_ctrl
//
// Write-only bus controller for an LCD12864 (ST7920-class) panel in 8-bit
// parallel mode. Upstream logic hands over one command/data byte at a time
// through a valid/ready handshake. The controller drives the byte onto the
// panel bus, waits a setup time, pulses lcd_en high, then waits for the panel
// to execute before taking the next byte. Clear (0x01) and home (0x02/0x03)
// commands get the longer CLR_CYC execution wait.
//
// Optional feature macro: LCD12864_CTRL_INIT_EN
//   When defined, a power-up delay of PWRUP_CYC cycles is followed by an
//   internal init sequence 0x30, 0x30, 0x0C, 0x01, 0x06 (rs=0). Upstream
//   requests are held off until init_done rises.
//   When undefined, the block is ready one cycle after reset and the
//   upstream sequencer must issue the panel init itself.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   req_valid  in   upstream has a byte to write
//   req_rs     in   0 = command, 1 = data
//   req_data   in   [7:0] byte to write
//   req_ready  out  controller accepts a byte on this cycle
//   init_done  out  init complete, stays high until reset
//   lcd_rs     out  panel register select
//   lcd_rw     out  panel read/write, tied low (write only)
//   lcd_en     out  panel enable strobe, byte latched on its falling edge
//   lcd_dat    out  [7:0] panel data bus
// ---------------------------------------------------------------------------
module lcd12864_bus_ctrl #(
  parameter int SETUP_CYC   = 2,
  parameter int EN_HIGH_CYC = 4,
  parameter int EXEC_CYC    = 8,
  parameter int CLR_CYC     = 20,
  parameter int PWRUP_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat
);

  // One down-counter times every phase, so it must hold the longest load.
  localparam int MAX_A   = (CLR_CYC > PWRUP_CYC) ? CLR_CYC : PWRUP_CYC;
  localparam int MAX_B   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > EXEC_CYC) ? MAX_C : EXEC_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_EN_HI = 3'd3,
    ST_EXEC  = 3'd4,
    ST_IDLE  = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_init_done;
  logic             r_lcd_rs;
  logic             r_lcd_en;
  logic [7:0]       r_lcd_dat;

`ifdef LCD12864_CTRL_INIT_EN
  logic [2:0]       r_init_idx;

  // Fixed panel init commands, issued in index order.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'h30;  // function set, 8-bit, basic instructions
      3'd1:    init_byte = 8'h30;  // repeated function set
      3'd2:    init_byte = 8'h0C;  // display on, cursor off
      3'd3:    init_byte = 8'h01;  // clear display (long wait)
      3'd4:    init_byte = 8'h06;  // entry mode: increment
      default: init_byte = 8'h00;
    endcase
  endfunction
`endif

  // Counter load for the execution wait: clear/home commands need CLR_CYC.
  function automatic logic [CNT_W-1:0] exec_load(input logic rs, input logic [7:0] dat);
    if (!rs && (dat == 8'h01 || dat == 8'h02 || dat == 8'h03)) begin
      exec_load = CNT_W'(CLR_CYC - 1);
    end else begin
      exec_load = CNT_W'(EXEC_CYC - 1);
    end
  endfunction

  // Sequencer: handshake, phase timing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcd_rs    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_dat   <= 8'h00;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
`ifdef LCD12864_CTRL_INIT_EN
      r_state     <= ST_PWRUP;
      r_cnt       <= CNT_W'(PWRUP_CYC - 1);
      r_init_idx  <= 3'd0;
`else
      r_state     <= ST_LOAD;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
`ifdef LCD12864_CTRL_INIT_EN
        ST_PWRUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // LOAD plays the role of the accept edge for internal init bytes.
        ST_LOAD: begin
          r_lcd_rs   <= 1'b0;
          r_lcd_dat  <= init_byte(r_init_idx);
          r_init_idx <= r_init_idx + 3'd1;
          r_cnt      <= CNT_W'(SETUP_CYC - 1);
          r_state    <= ST_SETUP;
        end
`else
        // First cycle out of reset: nothing to initialise, open for business.
        ST_LOAD: begin
          r_req_ready <= 1'b1;
          r_init_done <= 1'b1;
          r_state     <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_lcd_rs    <= req_rs;
            r_lcd_dat   <= req_data;
            r_req_ready <= 1'b0;
            r_cnt       <= CNT_W'(SETUP_CYC - 1);
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_lcd_en <= 1'b1;
            r_cnt    <= CNT_W'(EN_HIGH_CYC - 1);
            r_state  <= ST_EN_HI;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_EN_HI: begin
          if (r_cnt == '0) begin
            r_lcd_en <= 1'b0;
            r_cnt    <= exec_load(r_lcd_rs, r_lcd_dat);
            r_state  <= ST_EXEC;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
`ifdef LCD12864_CTRL_INIT_EN
            if (r_init_idx != 3'd5) begin
              r_state <= ST_LOAD;
            end else begin
              r_req_ready <= 1'b1;
              r_init_done <= 1'b1;
              r_state     <= ST_IDLE;
            end
`else
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // Illegal encoding: park the strobe and let the EXEC exit logic
        // decide where to resume on the next edge.
        default: begin
          r_lcd_en    <= 1'b0;
          r_req_ready <= 1'b0;
          r_cnt       <= '0;
          r_state     <= ST_EXEC;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign init_done = r_init_done;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = r_lcd_en;
  assign lcd_dat   = r_lcd_dat;

endmodule

// File: tb/tb_lcd12864_bus_ctrl.sv
`timescale 1ns/1ps
module tb_lcd12864_bus_ctrl;
  localparam int S = 2;
  localparam int E = 4;
  localparam int X = 8;
  localparam int C = 20;
  localparam int P = 16;
`ifdef LCD12864_CTRL_INIT_EN
  localparam int N_INIT = 5;
`else
  localparam int N_INIT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_dat;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  lcd12864_bus_ctrl #(
    .SETUP_CYC(S), .EN_HIGH_CYC(E), .EXEC_CYC(X), .CLR_CYC(C), .PWRUP_CYC(P)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at cycle %0d", name, cyc);
  endtask

  // ---------------- transaction-level reference model ----------------
  // Each write is described by its accept edge; outputs follow from offsets.
  logic [7:0] init_seq [5] = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};
  bit         m_valid = 0;
  logic [7:0] m_dat;
  logic       m_rs, m_en, m_ready, m_done;
  int         m_acc = -1, m_w = 0, m_go = -1, m_next = -1, m_idx = 0;

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? C : X;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_valid = 1; m_dat = 8'h00; m_rs = 0; m_en = 0; m_ready = 0; m_done = 0;
      m_acc = -1; m_idx = 0;
      if (N_INIT > 0) begin m_next = cyc + P + 1; m_go = -1; end
      else begin m_go = cyc + 1; m_next = -1; end
    end else if (m_valid) begin
      if (m_acc >= 0) begin
        m_en = (cyc >= m_acc + S) && (cyc < m_acc + S + E);
        if (cyc == m_acc + S + E + m_w) begin
          m_acc = -1;
          if (m_idx < N_INIT) m_next = cyc + 1;
          else begin m_ready = 1; m_done = 1; end
        end
      end else if (m_ready && req_valid) begin
        m_dat = req_data; m_rs = req_rs; m_ready = 0; m_acc = cyc;
        m_w = wait_len(req_rs, req_data);
      end else if (cyc == m_go) begin
        m_ready = 1; m_done = 1;
      end else if (cyc == m_next) begin
        m_dat = init_seq[m_idx]; m_rs = 0; m_idx++; m_acc = cyc;
        m_w = wait_len(1'b0, m_dat);
      end
    end
  end

  // ---------------- compare process + pulse log ----------------
  logic       prev_en = 1'b0;
  int         en_cyc_q[$];
  int         en_fall_q[$];
  logic [7:0] en_dat_q[$];

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("lcd_dat",   lcd_dat,   m_dat);
      chk("lcd_rs",    lcd_rs,    m_rs);
      chk("lcd_en",    lcd_en,    m_en);
      chk("lcd_rw",    lcd_rw,    1'b0);
      chk("req_ready", req_ready, m_ready);
      chk("init_done", init_done, m_done);
      if (lcd_en === 1'b1 && !prev_en) begin
        en_cyc_q.push_back(cyc);
        en_dat_q.push_back(lcd_dat);
      end
      if (lcd_en === 1'b0 && prev_en) en_fall_q.push_back(cyc);
      prev_en = (lcd_en === 1'b1);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    en_cyc_q.delete(); en_fall_q.delete(); en_dat_q.delete();
  endtask

  // Present a byte, wait for ready, return the accept edge; valid stays high.
  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    int n = 0;
    req_valid = 1'b1; req_rs = rs; req_data = d;
    while (req_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin timeout_fail("send"); acc = -1; end
    else acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic drop();
    req_valid = 1'b0;
    req_rs    = 1'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    while (req_ready !== 1'b1 && low < 400) begin low++; @(negedge clk); end
    if (low >= 400) timeout_fail("wait_ready");
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin n++; @(negedge clk); end
    if (n >= 400) timeout_fail("wait_init");
  endtask

  typedef struct { logic rs; logic [7:0] d; int low; } vec_t;
  vec_t vecs [7] = '{
    '{1'b1, 8'h4C, 14}, '{1'b0, 8'h01, 26}, '{1'b0, 8'h02, 26},
    '{1'b0, 8'h03, 26}, '{1'b0, 8'h04, 14}, '{1'b1, 8'h01, 14},
    '{1'b0, 8'h00, 14}
  };
  logic [7:0] b2b [3] = '{8'h80, 8'h41, 8'h42};

  initial begin
    int acc, acc2, low, rel, n;
    int accs [3];

    rst = 1'b1;
    tick(3);
    chk("rst_lcd_dat",   lcd_dat,   8'h00);
    chk("rst_lcd_en",    lcd_en,    1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    rst = 1'b0;
    rel = cyc;
`ifdef LCD12864_CTRL_INIT_EN
    wait_init(n);
    chk("init_done_cycle", cyc - rel, 103);
    chk("init_pulses", en_dat_q.size(), 5);
    for (int i = 0; i < 5 && i < en_dat_q.size(); i++) chk("init_byte", en_dat_q[i], init_seq[i]);
    if (en_cyc_q.size() == 5) begin
      chk("init_first_en", en_cyc_q[0] - rel, 19);
      chk("init_gap0", en_cyc_q[1] - en_cyc_q[0], 15);
      chk("init_gap2", en_cyc_q[3] - en_cyc_q[2], 15);
      chk("init_gap3", en_cyc_q[4] - en_cyc_q[3], 27);
    end
`else
    tick(1);
    chk("ready_after_reset", req_ready, 1'b1);
    chk("done_after_reset",  init_done, 1'b1);
`endif

    // Single writes: data, clear/home commands and their boundaries.
    for (int i = 0; i < 7; i++) begin
      clear_log();
      send(vecs[i].rs, vecs[i].d, acc);
      drop();
      chk("bus_dat", lcd_dat, vecs[i].d);
      chk("bus_rs",  lcd_rs,  vecs[i].rs);
      wait_ready(low);
      chk("ready_low", low, vecs[i].low);
      chk("en_pulses", en_cyc_q.size(), 1);
      if (en_cyc_q.size() > 0)  chk("en_first_cycle", en_cyc_q[0] + 1 - acc, 3);
      if (en_fall_q.size() > 0) chk("en_last_cycle",  en_fall_q[0] - acc, 6);
    end

    // Back-to-back with valid held high.
    clear_log();
    for (int i = 0; i < 3; i++) send(1'b0, b2b[i], accs[i]);
    drop();
    wait_ready(low);
    chk("b2b_acc_gap1", accs[1] - accs[0], 15);
    chk("b2b_acc_gap2", accs[2] - accs[1], 15);
    chk("b2b_pulses", en_cyc_q.size(), 3);
    if (en_cyc_q.size() == 3) begin
      chk("b2b_en_gap1", en_cyc_q[1] - en_cyc_q[0], 15);
      chk("b2b_en_gap2", en_cyc_q[2] - en_cyc_q[1], 15);
      for (int i = 0; i < 3; i++) chk("b2b_byte", en_dat_q[i], b2b[i]);
    end

    // Backpressure: new request raised at cycle 5 of a busy write.
    send(1'b1, 8'h55, acc);
    drop();
    tick(4);
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h66;
    n = 0;
    while (req_ready !== 1'b1 && n < 400) begin
      chk("bp_bus_stable", lcd_dat, 8'h55);
      @(negedge clk); n++;
    end
    if (n >= 400) timeout_fail("bp_ready");
    acc2 = cyc + 1;
    tick(1);
    drop();
    chk("bp_accept_gap", acc2 - acc, 15);
    chk("bp_new_byte", lcd_dat, 8'h66);
    wait_ready(low);

    // Reset while lcd_en is high.
    send(1'b1, 8'h33, acc);
    drop();
    n = 0;
    while (lcd_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("mid_en_high");
    rst = 1'b1;
    tick(1);
    chk("mid_rst_en",    lcd_en,    1'b0);
    chk("mid_rst_dat",   lcd_dat,   8'h00);
    chk("mid_rst_ready", req_ready, 1'b0);
    rst = 1'b0;
`ifdef LCD12864_CTRL_INIT_EN
    wait_init(n);
`else
    tick(1);
    chk("mid_rst_resume_ready", req_ready, 1'b1);
`endif
    clear_log();
    send(1'b1, 8'h5A, acc);
    drop();
    wait_ready(low);
    chk("resume_ready_low", low, 14);
    chk("resume_pulses", en_dat_q.size(), 1);
    if (en_dat_q.size() == 1) chk("resume_byte", en_dat_q[0], 8'h5A);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
